// File: rtl/move_pulse_gen.sv
// move_pulse_gen: turns the raw "move" pushbutton into one clean move pulse per press.
// Ports: clk; rst (sync, active-low); btn_in (raw level); move (1-cycle pulse);
//        held (debounced level); press_count (8-bit wrapping pulse count).
// Optional: define MOVE_PULSE_GEN_AUTO_REPEAT_EN for auto-repeat pulses while held.
module move_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter int REPEAT_DELAY    = 64,
    parameter int REPEAT_PERIOD   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       move,
    output logic       held,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             btn_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifdef MOVE_PULSE_GEN_AUTO_REPEAT_EN
    localparam logic [15:0] RDLY_LAST = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] RPER_LAST = 16'(REPEAT_PERIOD - 1);

    logic [15:0] rcnt;
    // 0 until the first repeat of this hold has fired
    logic        rep_phase;
`else
    logic unused_rep;
    assign unused_rep = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1          <= 1'b0;
            btn_s       <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            move        <= 1'b0;
            held        <= 1'b0;
            press_count <= 8'd0;
`ifdef MOVE_PULSE_GEN_AUTO_REPEAT_EN
            rcnt        <= 16'd0;
            rep_phase   <= 1'b0;
`endif
        end else begin
            s1    <= btn_in;
            btn_s <= s1;
            // move is a strobe: dropped on every edge unless re-armed below
            move  <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (btn_s) begin
                        state <= PRESS_WAIT;
                    end
                end
                PRESS_WAIT: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= HELD;
                        held        <= 1'b1;
                        move        <= 1'b1;
                        press_count <= press_count + 8'd1;
                        cnt         <= '0;
`ifdef MOVE_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt        <= 16'd0;
                        rep_phase   <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!btn_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef MOVE_PULSE_GEN_AUTO_REPEAT_EN
                    else if (rcnt == (rep_phase ? RPER_LAST : RDLY_LAST)) begin
                        move        <= 1'b1;
                        press_count <= press_count + 8'd1;
                        rcnt        <= 16'd0;
                        rep_phase   <= 1'b1;
                    end else begin
                        rcnt <= rcnt + 16'd1;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (btn_s) begin
                        // release bounce: back to HELD without a new pulse
                        state     <= HELD;
                        cnt       <= '0;
`ifdef MOVE_PULSE_GEN_AUTO_REPEAT_EN
                        rcnt      <= 16'd0;
                        rep_phase <= 1'b0;
`endif
                    end else if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        held  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    held  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_move_pulse_gen.sv
// tb_move_pulse_gen: randomized and directed bench for move_pulse_gen,
// compared against a run-length debounce model of the button.
module tb_move_pulse_gen;

    localparam int DEB  = 16;
    localparam int RDLY = 64;
    localparam int RPER = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_in = 1'b0;
    logic       move;
    logic       held;
    logic [7:0] press_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    move_pulse_gen #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RDLY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .move       (move),
        .held       (held),
        .press_count(press_count)
    );

    // Model: the button level seen two edges late must disagree with the
    // debounced level for DEB+1 consecutive edges before the level flips.
    bit         d1, d2, bs;
    bit         m_held;
    bit         m_move;
    logic [7:0] m_count;
    int         run;
    int         k;

    always @(posedge clk) begin
        if (!rst) begin
            d1 = 0; d2 = 0; m_held = 0; m_move = 0;
            m_count = 8'd0; run = 0; k = 0;
        end else begin
            bs = d2;
            d2 = d1;
            d1 = btn_in;
            m_move = 0;
            if (bs != m_held) begin
                run++;
                if (run == DEB + 1) begin
                    m_held = bs;
                    run = 0;
                    if (bs) begin
                        m_move = 1;
                        m_count = m_count + 8'd1;
                        k = 0;
                    end
                end
            end else begin
                if (m_held) begin
                    if (run > 0) k = 0;
                    else begin
                        k++;
`ifdef MOVE_PULSE_GEN_AUTO_REPEAT_EN
                        if (k == RDLY || (k > RDLY && (k - RDLY) % RPER == 0)) begin
                            m_move = 1;
                            m_count = m_count + 8'd1;
                        end
`endif
                    end
                end
                run = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_reset(input int n);
        rst = 1'b0;
        repeat (n) tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        btn_in = 1'b1;
        hold_reset(2);
        checks++;
        if (move !== 1'b0 || held !== 1'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL reset: move=%b held=%b count=%0d want 0 0 0",
                     move, held, press_count);
        end
        btn_in = 1'b0;
        hold_reset(2);
    endtask

    task automatic test_clean_press();
        hold_reset(2);
        btn_in = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (move !== (i == 19) || held !== (i >= 19)) begin
                failures++;
                $display("FAIL clean_press cyc %0d: move=%b held=%b want %b %b",
                         i, move, held, (i == 19), (i >= 19));
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            failures++;
            $display("FAIL clean_press count: got %0d want 1", press_count);
        end
        btn_in = 1'b0;
        repeat (25) tick();
        checks++;
        if (held !== 1'b0 || press_count !== 8'd1) begin
            failures++;
            $display("FAIL clean_release: held=%b count=%0d want 0 1",
                     held, press_count);
        end
    endtask

    task automatic test_glitch();
        hold_reset(2);
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < 20; i++) begin
                btn_in = (i < 10);
                tick();
                checks++;
                if (move !== 1'b0 || held !== 1'b0) begin
                    failures++;
                    $display("FAIL glitch %0d/%0d: move=%b held=%b want 0 0",
                             g, i, move, held);
                end
            end
        end
        checks++;
        if (press_count !== 8'd0) begin
            failures++;
            $display("FAIL glitch count: got %0d want 0", press_count);
        end
    endtask

    task automatic test_release_bounce();
        hold_reset(2);
        btn_in = 1'b1;
        repeat (25) tick();
        for (int s = 0; s < 10; s++) begin
            btn_in = s[0];
            repeat (3) begin
                tick();
                checks++;
                if (move !== 1'b0 || held !== 1'b1) begin
                    failures++;
                    $display("FAIL bounce seg %0d: move=%b held=%b want 0 1",
                             s, move, held);
                end
            end
        end
        btn_in = 1'b0;
        for (int i = 1; i <= 25; i++) begin
            tick();
            checks++;
            if (held !== (i < 19) || move !== 1'b0) begin
                failures++;
                $display("FAIL bounce fall cyc %0d: held=%b move=%b want %b 0",
                         i, held, move, (i < 19));
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            failures++;
            $display("FAIL bounce count: got %0d want 1", press_count);
        end
    endtask

    task automatic test_long_hold();
        int pulses;
        int want;
        bit prev;
`ifdef MOVE_PULSE_GEN_AUTO_REPEAT_EN
        want = 15;
`else
        want = 1;
`endif
        pulses = 0;
        prev = 0;
        hold_reset(2);
        for (int i = 1; i <= 330; i++) begin
            btn_in = (i <= 300);
            tick();
            if (move === 1'b1) pulses++;
            checks++;
            if (move !== m_move || held !== m_held || press_count !== m_count ||
                (prev && move)) begin
                failures++;
                $display("FAIL long_hold cyc %0d: move=%b held=%b cnt=%0d want %b %b %0d",
                         i, move, held, press_count, m_move, m_held, m_count);
            end
            prev = move;
        end
        checks++;
        if (press_count !== 8'(want) || pulses != want) begin
            failures++;
            $display("FAIL long_hold total: count=%0d pulses=%0d want %0d",
                     press_count, pulses, want);
        end
    endtask

    task automatic test_reset_mid();
        hold_reset(2);
        btn_in = 1'b1;
        repeat (13) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (move !== 1'b0 || held !== 1'b0 || press_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid: move=%b held=%b count=%0d want 0 0 0",
                     move, held, press_count);
        end
        rst = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            checks++;
            if (move !== (i == 19)) begin
                failures++;
                $display("FAIL reset_mid cyc %0d: move=%b want %b",
                         i, move, (i == 19));
            end
        end
        checks++;
        if (press_count !== 8'd1) begin
            failures++;
            $display("FAIL reset_mid count: got %0d want 1", press_count);
        end
        btn_in = 1'b0;
        repeat (25) tick();
    endtask

    task automatic test_wrap();
        int pulses;
        bit prev;
        pulses = 0;
        prev = 0;
        hold_reset(2);
        for (int p = 0; p < 257; p++) begin
            for (int i = 0; i < 75; i++) begin
                btn_in = (i < 25);
                tick();
                if (move === 1'b1) pulses++;
                checks++;
                if (move !== m_move || press_count !== m_count || (prev && move)) begin
                    failures++;
                    $display("FAIL wrap p%0d c%0d: move=%b cnt=%0d want %b %0d",
                             p, i, move, press_count, m_move, m_count);
                end
                prev = move;
            end
        end
        checks++;
        if (press_count !== 8'h01 || pulses != 257) begin
            failures++;
            $display("FAIL wrap total: count=%0h pulses=%0d want 01 257",
                     press_count, pulses);
        end
    endtask

    task automatic test_random();
        int len;
        hold_reset(2);
        for (int s = 0; s < 300; s++) begin
            btn_in = $urandom_range(0, 1);
            len = $urandom_range(1, 30);
            rst = ($urandom_range(0, 19) != 0);
            for (int i = 0; i < len; i++) begin
                tick();
                rst = 1'b1;
                checks++;
                if (move !== m_move || held !== m_held || press_count !== m_count) begin
                    failures++;
                    $display("FAIL random s%0d: move=%b held=%b cnt=%0d want %b %b %0d",
                             s, move, held, press_count, m_move, m_held, m_count);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        btn_in = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_long_hold();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
